// File: rtl/time_date_setter_pkg.sv
// Shared types and constants for the time/date setter and the decade clock counter:
// field widths, setter state encodings, blink masks, reset date and month-length helper.
package time_date_setter_pkg;

    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned DAY_W   = 5;
    localparam int unsigned MONTH_W = 4;
    localparam int unsigned YEAR_W  = 14;
    localparam int unsigned ST_W    = 3;

    // Edit states are consecutive so "next field" is state + 1
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_HOUR   = 3'd1;
    localparam logic [ST_W-1:0] ST_MIN    = 3'd2;
    localparam logic [ST_W-1:0] ST_SEC    = 3'd3;
    localparam logic [ST_W-1:0] ST_DAY    = 3'd4;
    localparam logic [ST_W-1:0] ST_MONTH  = 3'd5;
    localparam logic [ST_W-1:0] ST_YEAR   = 3'd6;
    localparam logic [ST_W-1:0] ST_COMMIT = 3'd7;

    localparam logic [7:0] BLANK_HOUR_DAY  = 8'hC0;
    localparam logic [7:0] BLANK_MIN_MONTH = 8'h30;
    localparam logic [7:0] BLANK_SEC       = 8'h0C;
    localparam logic [7:0] BLANK_YEAR      = 8'h0F;

    localparam int unsigned REPEAT_DELAY_CYCLES  = 25_000_000;
    localparam int unsigned REPEAT_PERIOD_CYCLES = 5_000_000;

    typedef struct packed {
        logic [YEAR_W-1:0]  year;
        logic [MONTH_W-1:0] month;
        logic [DAY_W-1:0]   day;
        logic [HOUR_W-1:0]  hour;
        logic [MIN_W-1:0]   min;
        logic [SEC_W-1:0]   sec;
    } date_time_t;

    localparam date_time_t RESET_DATE_TIME = '{year: 14'd2024, month: 4'd1, day: 5'd1,
                                               hour: 5'd0, min: 6'd0, sec: 6'd0};

    function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                       input logic [YEAR_W-1:0]  year);
        logic leap;
        leap = (year[1:0] == 2'b00) &&
               (((year % 14'd100) != 14'd0) || ((year % 14'd400) == 14'd0));
        case (month)
            4'd2:                    return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                 return 5'd31;
        endcase
    endfunction

    function automatic logic is_edit(input logic [ST_W-1:0] st);
        return (st != ST_IDLE) && (st != ST_COMMIT);
    endfunction

    function automatic logic [7:0] field_blank(input logic [ST_W-1:0] st);
        case (st)
            ST_HOUR, ST_DAY:  return BLANK_HOUR_DAY;
            ST_MIN, ST_MONTH: return BLANK_MIN_MONTH;
            ST_SEC:           return BLANK_SEC;
            ST_YEAR:          return BLANK_YEAR;
            default:          return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/time_date_setter_if.sv
// Setter <-> counter link: live counter values in, shadow values and load/hold strobes out.
interface time_date_setter_if;
    import time_date_setter_pkg::*;

    logic [SEC_W-1:0]   cur_sec;
    logic [MIN_W-1:0]   cur_min;
    logic [HOUR_W-1:0]  cur_hour;
    logic [DAY_W-1:0]   cur_day;
    logic [MONTH_W-1:0] cur_month;
    logic [YEAR_W-1:0]  cur_year;
    logic [SEC_W-1:0]   set_sec;
    logic [MIN_W-1:0]   set_min;
    logic [HOUR_W-1:0]  set_hour;
    logic [DAY_W-1:0]   set_day;
    logic [MONTH_W-1:0] set_month;
    logic [YEAR_W-1:0]  set_year;
    logic               set_load;
    logic               edit_active;

    modport master (
        input  cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
        output set_sec, set_min, set_hour, set_day, set_month, set_year,
        output set_load, edit_active
    );

    modport slave (
        output cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
        input  set_sec, set_min, set_hour, set_day, set_month, set_year,
        input  set_load, edit_active
    );

endinterface

// File: rtl/time_date_setter_button_conditioner.sv
// Raw active-low key -> 2-FF sync, debounce, one-cycle press pulse.
// With SETTER_AUTOREPEAT_EN defined, REPEAT_EN instances also repeat while held.
module time_date_setter_button_conditioner
    import time_date_setter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
`ifdef SETTER_AUTOREPEAT_EN
   ,parameter bit          REPEAT_EN       = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q;
    logic             pressed_sync;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rep_fire;

    assign pressed_sync = ~sync_q[1];

    // Accept a new level only after it differed from the accepted one for DEBOUNCE_CYCLES in a row
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (pressed_sync != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = pressed_sync;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = (stable_d & ~stable_q) | rep_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_n};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

`ifdef SETTER_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_DELAY_CYCLES + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             armed_q, armed_d;

    // First repeat after the long hold delay, then at the shorter period
    always_comb begin
        rep_cnt_d = '0;
        armed_d   = 1'b0;
        rep_fire  = 1'b0;
        if (REPEAT_EN && stable_q && stable_d) begin
            armed_d   = armed_q;
            rep_cnt_d = rep_cnt_q + REP_W'(1);
            if (rep_cnt_q == (armed_q ? REP_W'(REPEAT_PERIOD_CYCLES - 1)
                                      : REP_W'(REPEAT_DELAY_CYCLES - 1))) begin
                rep_cnt_d = '0;
                armed_d   = 1'b1;
                rep_fire  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            armed_q   <= armed_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign press = press_q;

endmodule

// File: rtl/time_date_setter.sv
// Button-driven time/date editor: edits a shadow copy field by field and commits it with a one-cycle load.
// Optional build macro SETTER_AUTOREPEAT_EN enables hold-to-repeat on the increase/decrease keys.
module time_date_setter
    import time_date_setter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLINK_CYCLES    = 12_500_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000,
    parameter int unsigned YEAR_MIN        = 2000,
    parameter int unsigned YEAR_MAX        = 2099
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                butt_increase,
    input  logic                butt_decrease,
    input  logic                butt_change,
    time_date_setter_if.master  tdif,
    output logic                disp_date,
    output logic [7:0]          blank_mask
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BLK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [YEAR_W-1:0] YR_MIN = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] YR_MAX = YEAR_W'(YEAR_MAX);

    logic inc_ev, dec_ev, chg_ev;

    time_date_setter_button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef SETTER_AUTOREPEAT_EN
       ,.REPEAT_EN      (1'b1)
`endif
    ) u_inc (.clk(clk), .rst_n(rst_n), .btn_n(butt_increase), .press(inc_ev));

    time_date_setter_button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef SETTER_AUTOREPEAT_EN
       ,.REPEAT_EN      (1'b1)
`endif
    ) u_dec (.clk(clk), .rst_n(rst_n), .btn_n(butt_decrease), .press(dec_ev));

    time_date_setter_button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chg (.clk(clk), .rst_n(rst_n), .btn_n(butt_change), .press(chg_ev));

    logic [ST_W-1:0]  state_q, state_d;
    date_time_t       shadow_q, shadow_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
    logic             set_load_q, set_load_d;
    logic             edit_active_q, edit_active_d;
    logic             disp_date_q, disp_date_d;
    logic [7:0]       blank_mask_q, blank_mask_d;
    logic             any_ev, step_up, step_dn, restart;
    logic [DAY_W-1:0] dim_cur, dim_new;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        tmo_d       = tmo_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        any_ev      = inc_ev | dec_ev | chg_ev;
        step_up     = inc_ev & ~dec_ev;
        step_dn     = dec_ev & ~inc_ev;
        dim_cur     = days_in_month(shadow_q.month, shadow_q.year);

        case (state_q)
            ST_IDLE: begin
                if (chg_ev) begin
                    state_d  = ST_HOUR;
                    shadow_d = '{year: tdif.cur_year, month: tdif.cur_month, day: tdif.cur_day,
                                 hour: tdif.cur_hour, min: tdif.cur_min, sec: tdif.cur_sec};
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default: begin
                if (chg_ev) begin
                    state_d = state_q + ST_W'(1);
                end else if (step_up || step_dn) begin
                    case (state_q)
                        ST_HOUR: shadow_d.hour = step_up
                            ? ((shadow_q.hour >= 5'd23) ? 5'd0  : shadow_q.hour + 5'd1)
                            : ((shadow_q.hour == 5'd0)  ? 5'd23 : shadow_q.hour - 5'd1);
                        ST_MIN: shadow_d.min = step_up
                            ? ((shadow_q.min >= 6'd59) ? 6'd0  : shadow_q.min + 6'd1)
                            : ((shadow_q.min == 6'd0)  ? 6'd59 : shadow_q.min - 6'd1);
                        ST_SEC: shadow_d.sec = step_up
                            ? ((shadow_q.sec >= 6'd59) ? 6'd0  : shadow_q.sec + 6'd1)
                            : ((shadow_q.sec == 6'd0)  ? 6'd59 : shadow_q.sec - 6'd1);
                        ST_DAY: shadow_d.day = step_up
                            ? ((shadow_q.day >= dim_cur) ? 5'd1    : shadow_q.day + 5'd1)
                            : ((shadow_q.day <= 5'd1)    ? dim_cur : shadow_q.day - 5'd1);
                        ST_MONTH: shadow_d.month = step_up
                            ? ((shadow_q.month >= 4'd12) ? 4'd1  : shadow_q.month + 4'd1)
                            : ((shadow_q.month <= 4'd1)  ? 4'd12 : shadow_q.month - 4'd1);
                        default: shadow_d.year = step_up
                            ? ((shadow_q.year >= YR_MAX) ? YR_MIN : shadow_q.year + 14'd1)
                            : ((shadow_q.year <= YR_MIN) ? YR_MAX : shadow_q.year - 14'd1);
                    endcase
                end else if (!any_ev && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Month/year edits pull the day back into the new month's range in the same update
        dim_new = days_in_month(shadow_d.month, shadow_d.year);
        if ((state_q == ST_MONTH || state_q == ST_YEAR) && (shadow_d.day > dim_new)) begin
            shadow_d.day = dim_new;
        end

        restart = (state_d != state_q) || any_ev || !is_edit(state_d);
        if (restart) begin
            tmo_d       = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
            if (blink_cnt_q == BLK_W'(BLINK_CYCLES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end

        set_load_d    = (state_d == ST_COMMIT);
        edit_active_d = is_edit(state_d);
        disp_date_d   = (state_d == ST_DAY) || (state_d == ST_MONTH) || (state_d == ST_YEAR);
        blank_mask_d  = phase_d ? field_blank(state_d) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            shadow_q      <= RESET_DATE_TIME;
            tmo_q         <= '0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b0;
            set_load_q    <= 1'b0;
            edit_active_q <= 1'b0;
            disp_date_q   <= 1'b0;
            blank_mask_q  <= 8'h00;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            tmo_q         <= tmo_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
            set_load_q    <= set_load_d;
            edit_active_q <= edit_active_d;
            disp_date_q   <= disp_date_d;
            blank_mask_q  <= blank_mask_d;
        end
    end

    assign tdif.set_sec     = shadow_q.sec;
    assign tdif.set_min     = shadow_q.min;
    assign tdif.set_hour    = shadow_q.hour;
    assign tdif.set_day     = shadow_q.day;
    assign tdif.set_month   = shadow_q.month;
    assign tdif.set_year    = shadow_q.year;
    assign tdif.set_load    = set_load_q;
    assign tdif.edit_active = edit_active_q;
    assign disp_date        = disp_date_q;
    assign blank_mask       = blank_mask_q;

endmodule

// File: tb/tb_time_date_setter.sv
// Directed self-checking bench for time_date_setter with short debounce/blink/timeout constants.
module tb_time_date_setter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       b_inc = 1'b1;
    logic       b_dec = 1'b1;
    logic       b_chg = 1'b1;
    logic       disp_date;
    logic [7:0] blank_mask;
    logic [7:0] mask_acc;
    logic [63:0] cur_set;
    logic [63:0] load_val = '0;
    int          load_cnt = 0;
    int          n_cmp    = 0;
    int          n_err    = 0;

    time_date_setter_if tdif();

    time_date_setter #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_CYCLES   (8),
        .TIMEOUT_CYCLES (200),
        .YEAR_MIN       (2000),
        .YEAR_MAX       (2099)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .butt_increase(b_inc),
        .butt_decrease(b_dec),
        .butt_change  (b_chg),
        .tdif         (tdif),
        .disp_date    (disp_date),
        .blank_mask   (blank_mask)
    );

    always #5 clk = ~clk;

    assign cur_set = {24'd0, tdif.set_year, tdif.set_month, tdif.set_day,
                      tdif.set_hour, tdif.set_min, tdif.set_sec};

    always @(negedge clk) begin
        if (tdif.set_load) begin
            load_cnt <= load_cnt + 1;
            load_val <= cur_set;
        end
    end

    function automatic logic [63:0] dt(input int y, input int mo, input int d,
                                       input int h, input int mi, input int s);
        return {24'd0, 14'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cur(input int y, input int mo, input int d,
                           input int h, input int mi, input int s);
        tdif.cur_year  = 14'(y);
        tdif.cur_month = 4'(mo);
        tdif.cur_day   = 5'(d);
        tdif.cur_hour  = 5'(h);
        tdif.cur_min   = 6'(mi);
        tdif.cur_sec   = 6'(s);
    endtask

    task automatic press(input logic inc, input logic dec, input logic chg, input int hold);
        @(negedge clk);
        b_inc = ~inc;
        b_dec = ~dec;
        b_chg = ~chg;
        repeat (hold) @(negedge clk);
        b_inc = 1'b1;
        b_dec = 1'b1;
        b_chg = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic mask_window();
        mask_acc = 8'h00;
        repeat (20) begin
            @(negedge clk);
            mask_acc = mask_acc | blank_mask;
        end
    endtask

    initial begin
        set_cur(2024, 2, 29, 23, 59, 50);
        repeat (3) @(negedge clk);
        check_eq("rst_set_load",    64'(tdif.set_load),    64'd0);
        check_eq("rst_edit_active", 64'(tdif.edit_active), 64'd0);
        check_eq("rst_disp_date",   64'(disp_date),        64'd0);
        check_eq("rst_blank",       64'(blank_mask),       64'd0);
        check_eq("rst_shadow",      cur_set,               dt(2024, 1, 1, 0, 0, 0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Full edit/commit pass
        press(0, 0, 1, 8);
        check_eq("s1_copy",        cur_set,               dt(2024, 2, 29, 23, 59, 50));
        check_eq("s1_edit_active", 64'(tdif.edit_active), 64'd1);
        check_eq("s1_disp_hour",   64'(disp_date),        64'd0);
        mask_window();
        check_eq("s1_mask_hour",   64'(mask_acc),         64'hC0);
        press(1, 0, 0, 8);
        check_eq("s1_hour_wrap",   cur_set,               dt(2024, 2, 29, 0, 59, 50));
        for (int i = 0; i < 5; i++) press(0, 0, 1, 8);
        check_eq("s1_no_early_ld", 64'(load_cnt),         64'd0);
        press(0, 0, 1, 8);
        check_eq("s1_load_cnt",    64'(load_cnt),         64'd1);
        check_eq("s1_load_val",    load_val,              dt(2024, 2, 29, 0, 59, 50));
        check_eq("s1_idle_after",  64'(tdif.edit_active), 64'd0);

        // Glitch rejection, single step, month clamp in non-leap year, timeout
        set_cur(2023, 3, 31, 10, 20, 30);
        press(0, 0, 1, 8);
        press(0, 0, 1, 8);
        press(1, 0, 0, 2);
        check_eq("s2_glitch",      cur_set,               dt(2023, 3, 31, 10, 20, 30));
        press(1, 0, 0, 10);
        check_eq("s2_press10",     cur_set,               dt(2023, 3, 31, 10, 21, 30));
        press(0, 0, 1, 8);
        press(0, 0, 1, 8);
        check_eq("s2_disp_day",    64'(disp_date),        64'd1);
        press(0, 0, 1, 8);
        mask_window();
        check_eq("s2_mask_month",  64'(mask_acc),         64'h30);
        press(0, 1, 0, 8);
        check_eq("s2_clamp_feb",   cur_set,               dt(2023, 2, 28, 10, 21, 30));
        repeat (220) @(negedge clk);
        check_eq("s2_timeout",     64'(tdif.edit_active), 64'd0);
        check_eq("s2_no_load",     64'(load_cnt),         64'd1);

        // Leap-year clamp, year wrap both ways, commit
        set_cur(2000, 3, 31, 12, 0, 0);
        for (int i = 0; i < 5; i++) press(0, 0, 1, 8);
        press(0, 1, 0, 8);
        check_eq("s3_clamp_leap",  cur_set,               dt(2000, 2, 29, 12, 0, 0));
        press(0, 0, 1, 8);
        mask_window();
        check_eq("s3_mask_year",   64'(mask_acc),         64'h0F);
        press(0, 1, 0, 8);
        check_eq("s3_year_dn",     cur_set,               dt(2099, 2, 28, 12, 0, 0));
        press(1, 0, 0, 8);
        check_eq("s3_year_up",     cur_set,               dt(2000, 2, 28, 12, 0, 0));
        press(0, 0, 1, 8);
        check_eq("s3_load_cnt",    64'(load_cnt),         64'd2);
        check_eq("s3_load_val",    load_val,              dt(2000, 2, 28, 12, 0, 0));

        // Priority rules, second wrap, abort in DAY
        set_cur(2050, 6, 15, 5, 6, 0);
        press(0, 0, 1, 8);
        press(1, 0, 1, 8);
        check_eq("s4_chg_prio",    cur_set,               dt(2050, 6, 15, 5, 6, 0));
        mask_window();
        check_eq("s4_in_min",      64'(mask_acc),         64'h30);
        press(1, 1, 0, 8);
        check_eq("s4_inc_dec",     cur_set,               dt(2050, 6, 15, 5, 6, 0));
        press(0, 0, 1, 8);
        press(0, 1, 0, 8);
        check_eq("s4_sec_wrap",    cur_set,               dt(2050, 6, 15, 5, 6, 59));
        press(0, 0, 1, 8);
        check_eq("s4_disp_day",    64'(disp_date),        64'd1);
        repeat (230) @(negedge clk);
        check_eq("s4_timeout",     64'(tdif.edit_active), 64'd0);
        check_eq("s4_disp_off",    64'(disp_date),        64'd0);
        check_eq("s4_blank_off",   64'(blank_mask),       64'd0);
        check_eq("s4_no_load",     64'(load_cnt),         64'd2);

        // Asynchronous reset in the middle of an edit
        set_cur(2031, 7, 4, 8, 9, 10);
        press(0, 0, 1, 8);
        check_eq("s5_editing",     64'(tdif.edit_active), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("s5_rst_edit",    64'(tdif.edit_active), 64'd0);
        check_eq("s5_rst_load",    64'(tdif.set_load),    64'd0);
        check_eq("s5_rst_disp",    64'(disp_date),        64'd0);
        check_eq("s5_rst_blank",   64'(blank_mask),       64'd0);
        check_eq("s5_rst_shadow",  cur_set,               dt(2024, 1, 1, 0, 0, 0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("s5_load_total",  64'(load_cnt),         64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
